// File: rtl/rom_burst_arbiter.sv
// Two-requester round-robin arbiter that streams bursts of words out of a shared
// registered ROM, returning each word one cycle after its address is issued.
module rom_burst_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int MAXLEN = 16,
  localparam int ADDRW = $clog2(DEPTH),
  localparam int LENW  = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [ADDRW-1:0] req_addr0,
  input  logic [ADDRW-1:0] req_addr1,
  input  logic [LENW-1:0]  req_len0,
  input  logic [LENW-1:0]  req_len1,
  output logic [1:0]       req_ready,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [LENW-1:0]  cnt;
  logic             owner;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [ADDRW-1:0] sel_addr;
  logic [LENW-1:0]  sel_len;
  logic [ADDRW-1:0] next_addr;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign req_ready = (state == IDLE && !rst && req_valid != 2'b00) ?
                     (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |req_ready;
  assign sel_addr  = grant ? req_addr1 : req_addr0;
  assign sel_len   = grant ? req_len1 : req_len0;
  assign next_addr = (rom_addr == ADDRW'(DEPTH - 1)) ? '0 : rom_addr + 1'b1;

  // rom_addr is loaded with the base on acceptance and only advances between issues,
  // so it naturally holds the last issued address once the burst ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 2'b00;
      rsp_last   <= 1'b0;
    end else begin
      rsp_valid <= (state == BURST) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      rsp_last  <= (state == BURST) && (cnt == LENW'(1));
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            if (sel_len != '0) begin
              state    <= BURST;
              rom_addr <= sel_addr;
              cnt      <= sel_len;
              owner    <= grant;
            end
          end
        end
        BURST: begin
          if (cnt == LENW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt      <= cnt - LENW'(1);
            rom_addr <= next_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_data = (|rsp_valid) ? rom_data : '0;
  assign busy     = (state == BURST);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: directed scenarios plus random traffic, checked
// against a cycle-scheduled transaction model of issues and responses.
module tb_rom_burst_arbiter;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 256;
  localparam int MAXLEN = 16;
  localparam int ADDRW  = 8;
  localparam int LENW   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [ADDRW-1:0] req_addr0 = '0;
  logic [ADDRW-1:0] req_addr1 = '0;
  logic [LENW-1:0]  req_len0 = '0;
  logic [LENW-1:0]  req_len1 = '0;
  logic [1:0]       req_ready;
  logic [ADDRW-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_last;
  logic             busy;

  rom_burst_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_len0(req_len0), .req_len1(req_len1), .req_ready(req_ready),
    .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;
  int idleFrom = 0;
  bit lastGrant = 1'b1;
  logic [ADDRW-1:0] expAddr = '0;
  logic [1:0] accMask;
  // Expected activity per cycle, indexed by cycle number modulo 64.
  bit issueV [64];
  int issueA [64];
  bit rspV [64];
  int rspA [64];
  bit rspO [64];
  bit rspL [64];

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task clearModel;
    for (int i = 0; i < 64; i++) begin
      issueV[i] = 0; rspV[i] = 0;
    end
  endtask

  task checkCycle;
    int s;
    s = cyc % 64;
    if (issueV[s]) expAddr = ADDRW'(issueA[s]);
    checkOutput("rom_addr", 32'(rom_addr), 32'(expAddr));
    checkOutput("busy", 32'(busy), 32'(issueV[s]));
    checkOutput("rsp_valid", 32'(rsp_valid), rspV[s] ? (rspO[s] ? 32'd2 : 32'd1) : 32'd0);
    checkOutput("rsp_data", 32'(rsp_data), rspV[s] ? 32'(mem[rspA[s]]) : 32'd0);
    checkOutput("rsp_last", 32'(rsp_last), 32'(rspV[s] && rspL[s]));
    issueV[s] = 0;
    rspV[s] = 0;
  endtask

  task applyStimulus(input logic [1:0] v, input int a0, input int l0, input int a1, input int l1);
    int g, base, len, c;
    logic [1:0] expReady;
    req_valid = v;
    req_addr0 = ADDRW'(a0); req_len0 = LENW'(l0);
    req_addr1 = ADDRW'(a1); req_len1 = LENW'(l1);
    #1;
    expReady = 2'b00;
    g = 0;
    if (cyc >= idleFrom && v != 2'b00) begin
      g = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : (lastGrant ? 0 : 1);
      expReady = 2'(1 << g);
    end
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    accMask = expReady;
    if (expReady != 2'b00) begin
      lastGrant = g[0];
      base = g ? a1 : a0;
      len = g ? l1 : l0;
      c = cyc + 1;
      if (len > 0) begin
        for (int k = 0; k < len; k++) begin
          issueV[(c + k) % 64] = 1;
          issueA[(c + k) % 64] = (base + k) % DEPTH;
          rspV[(c + k + 1) % 64] = 1;
          rspA[(c + k + 1) % 64] = (base + k) % DEPTH;
          rspO[(c + k + 1) % 64] = g[0];
          rspL[(c + k + 1) % 64] = (k == len - 1);
        end
        idleFrom = c + len;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkCycle();
  endtask

  task idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 0, 0, 0, 0);
  endtask

  task doReset;
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_rsp_last", 32'(rsp_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
    clearModel();
    lastGrant = 1'b1;
    expAddr = '0;
    idleFrom = cyc;
    #1;
    checkCycle();
  endtask

  bit pend [2];
  int pa [2];
  int pl [2];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    clearModel();
    #2;
    doReset();

    // single burst from requester 0
    applyStimulus(2'b01, 'h10, 4, 0, 0);
    idleCycles(6);

    // contention from reset with both held: grants alternate starting at 0
    doReset();
    repeat (14) applyStimulus(2'b11, 'h20, 2, 'h40, 2);
    idleCycles(4);

    // address wrap for requester 1
    applyStimulus(2'b10, 0, 0, 'hFE, 4);
    idleCycles(6);

    // zero-length request, then contention goes to requester 1
    applyStimulus(2'b01, 5, 0, 0, 0);
    applyStimulus(2'b11, 5, 0, 'h30, 1);
    idleCycles(3);

    // reset after the second issue of a long burst, then a fresh short burst
    applyStimulus(2'b01, 'h80, 8, 0, 0);
    applyStimulus(2'b00, 0, 0, 0, 0);
    doReset();
    idleCycles(3);
    applyStimulus(2'b01, 'h55, 1, 0, 0);
    idleCycles(3);

    // requester 1 held while a maximum-length burst runs
    applyStimulus(2'b01, 'h70, MAXLEN, 0, 0);
    pend[1] = 1;
    for (int i = 0; i < MAXLEN + 4; i++) begin
      applyStimulus({pend[1], 1'b0}, 0, 0, 'hA0, 3);
      if (accMask[1]) pend[1] = 0;
    end
    idleCycles(4);

    // random traffic with occasional resets
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          pa[i] = int'($urandom_range(0, DEPTH - 1));
          pl[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, MAXLEN));
        end
      end
      applyStimulus({pend[1], pend[0]}, pa[0], pl[0], pa[1], pl[1]);
      for (int i = 0; i < 2; i++) if (accMask[i]) pend[i] = 0;
      if ($urandom_range(0, 399) == 0) doReset();
    end
    idleCycles(MAXLEN + 2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rom_burst_arbiter.md
ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, ROM word width.
- DEPTH, 256, ROM words.
- ADDRW, $clog2(DEPTH) (localparam), ROM address width.
- MAXLEN, 16, maximum burst length in words.
- LENW, $clog2(MAXLEN+1) (localparam), burst length field width.

REQ-002 Ports SHALL be, one per line:
- clk, in, 1, sole clock; all state on posedge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 2, per-requester burst request (bit i = requester i).
- req_addr0 / req_addr1, in, ADDRW, burst start address.
- req_len0 / req_len1, in, LENW, burst length (0..MAXLEN).
- req_ready, out, 2, per-requester accept (combinational).
- rom_addr, out, ADDRW, address to the shared 1-cycle-latency registered ROM.
- rom_data, in, WIDTH, ROM read data.
- rsp_valid, out, 2, one-hot response strobe tagging the owning requester.
- rsp_data, out, WIDTH, response word.
- rsp_last, out, 1, marks final word of burst.
- busy, out, 1, high while in BURST.

Function
REQ-003 Clock and reset SHALL be one clock; reset asynchronous and active-high.
REQ-004 FSM SHALL have two states:
- IDLE to BURST on acceptance with len>=1.
- BURST to IDLE after the issue cycle where the remaining count reaches 1.
REQ-005 A request SHALL transfer at the posedge where req_valid[i] and req_ready[i] are both high.
- req_ready SHALL be high only in IDLE, for at most one requester.
REQ-006 Arbitration SHALL be round-robin.
- If exactly one req_valid is set, that requester is granted.
- If both are set, the requester not equal to last_grant is granted.
- last_grant SHALL update on every acceptance.
REQ-007 req_addr and req_len SHALL be sampled only at acceptance; later changes are ignored.
REQ-008 A len=0 request SHALL be accepted and update last_grant, then FSM stays IDLE with no response.
REQ-009 Each BURST cycle SHALL issue one read with rom_addr = base + k (k = 0..len-1).
- Address arithmetic SHALL be modulo DEPTH (wraps DEPTH-1 to 0).
REQ-010 rom_addr SHALL hold its last issued value outside BURST.
REQ-011 Response latency SHALL be exactly one cycle after issue.
- rsp_valid SHALL be the issue strobe registered once, one-hot with the owner tag.
- rsp_data SHALL equal rom_data, passed through in the same cycle.
- rsp_last SHALL be high with the response for k = len-1.
- rsp_data SHALL be 0 when rsp_valid is 0.
REQ-012 Accepting a burst of len L at edge E0 SHALL produce:
- issues in the L cycles after E0;
- rsp_valid in the L cycles after E1;
- FSM back in IDLE at edge E0+L.
REQ-013 Back-to-back bursts SHALL have exactly one IDLE cycle between the last issue and the next first issue.
REQ-014 Requests raised during BURST SHALL wait; req_ready stays 0 and no request is dropped while req_valid is held.
REQ-015 No responses SHALL be generated for a requester while another requester's burst is in progress.
REQ-016 busy SHALL equal (state == BURST).

Reset
REQ-017 Asserting rst SHALL immediately force, without waiting for clk:
- state IDLE;
- rom_addr 0, rsp_valid 0, rsp_data 0, rsp_last 0, busy 0, req_ready 0;
- internal counters 0;
- last_grant 1, so requester 0 wins the first contention.
REQ-018 Reset mid-burst SHALL abandon the burst.
- No further rsp_valid for it after release.
- First post-reset acceptance behaves as after power-up.

Verification
REQ-019 Single burst: req0 addr=0x10 len=4, ROM[i]=i -> rom_addr 0x10..0x13 on consecutive cycles; rsp_valid=01 with data 10,11,12,13 one cycle later; rsp_last on 13.
REQ-020 Contention: both valid from reset, len=2 each -> req0 served first, then req1 after one IDLE cycle; with both held, grants alternate 0,1,0,1.
REQ-021 Wrap: req1 addr=0xFE len=4 -> rom_addr FE,FF,00,01; rsp_valid=10, rsp_last on the word from address 01.
REQ-022 len=0: req0 len=0 -> req_ready pulses once, no rsp_valid, busy stays 0, and a following req1 is granted.
REQ-023 Reset mid-burst: rst asserted after the 2nd issue of a len=8 burst -> outputs 0 asynchronously and no rsp_valid after release; a new req0 len=1 completes normally.
REQ-024 Hold during busy: req1 rises while req0 len=MAXLEN is in BURST -> req_ready[1]=0 throughout; req1 is accepted in the first IDLE cycle.
